// File: rtl/data_ram_arbiter.sv
// Single-port RAM controller shared by instruction fetch and data load/store.
// One request in flight; data has priority unless instruction fetch has been starved.
module data_ram_arbiter #(
   parameter int MAX_WAIT     = 15,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req_valid,
   input  logic [31:0] inst_req_addr,
   output logic        inst_req_ready,
   output logic        inst_resp_valid,
   output logic [31:0] inst_resp_rdata,
   output logic        inst_resp_err,
   input  logic        data_req_valid,
   input  logic        data_req_write,
   input  logic [3:0]  data_req_sel,
   input  logic [31:0] data_req_addr,
   input  logic [31:0] data_req_wdata,
   output logic        data_req_ready,
   output logic        data_resp_valid,
   output logic [31:0] data_resp_rdata,
   output logic        data_resp_err,
   output logic        ram_en,
   output logic [3:0]  ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ack
);

   typedef enum logic [1:0] {IDLE, INST_BUSY, DATA_BUSY, RESP} state_t;

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [3:0]  starve_cnt;
   logic        req_write;

   logic        inst_force;
   logic        data_grant;
   logic        inst_grant;
   logic        data_misaligned;
   logic        inst_misaligned;
   logic [3:0]  data_we;
   logic [31:0] data_wdata_rep;

   // Instruction fetch wins only once it has lost STARVE_LIMIT grants in a row.
   assign inst_force     = (starve_cnt == 4'(STARVE_LIMIT)) && inst_req_valid;
   assign data_grant     = (state == IDLE) && data_req_valid && !inst_force;
   assign inst_grant     = (state == IDLE) && inst_req_valid && !data_grant;
   assign data_req_ready = data_grant;
   assign inst_req_ready = inst_grant;

   assign inst_misaligned = |inst_req_addr[1:0];
   assign data_we         = data_req_write ? 4'(data_req_sel << data_req_addr[1:0]) : 4'b0000;

   always_comb begin
      data_misaligned = 1'b0;
      data_wdata_rep  = data_req_wdata;
      case (data_req_sel)
         4'b0001: data_wdata_rep = {4{data_req_wdata[7:0]}};
         4'b0011: begin
            data_wdata_rep  = {2{data_req_wdata[15:0]}};
            data_misaligned = data_req_addr[0];
         end
         4'b1111: data_misaligned = |data_req_addr[1:0];
         default: data_misaligned = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         wait_cnt        <= '0;
         starve_cnt      <= '0;
         req_write       <= 1'b0;
         inst_resp_valid <= 1'b0;
         inst_resp_rdata <= '0;
         inst_resp_err   <= 1'b0;
         data_resp_valid <= 1'b0;
         data_resp_rdata <= '0;
         data_resp_err   <= 1'b0;
         ram_en          <= 1'b0;
         ram_we          <= '0;
         ram_addr        <= '0;
         ram_wdata       <= '0;
      end else begin
         // Response outputs are single-cycle pulses and read as zero otherwise.
         inst_resp_valid <= 1'b0;
         inst_resp_rdata <= '0;
         inst_resp_err   <= 1'b0;
         data_resp_valid <= 1'b0;
         data_resp_rdata <= '0;
         data_resp_err   <= 1'b0;

         case (state)
            IDLE: begin
               if (inst_grant || !inst_req_valid)
                  starve_cnt <= '0;
               else if (data_grant && starve_cnt != 4'hF)
                  starve_cnt <= starve_cnt + 4'd1;

               if (data_grant) begin
                  req_write <= data_req_write;
                  if (data_misaligned) begin
                     state           <= RESP;
                     data_resp_valid <= 1'b1;
                     data_resp_err   <= 1'b1;
                  end else begin
                     state     <= DATA_BUSY;
                     ram_en    <= 1'b1;
                     ram_we    <= data_we;
                     ram_addr  <= {data_req_addr[31:2], 2'b00};
                     ram_wdata <= data_wdata_rep;
                  end
               end else if (inst_grant) begin
                  req_write <= 1'b0;
                  if (inst_misaligned) begin
                     state           <= RESP;
                     inst_resp_valid <= 1'b1;
                     inst_resp_err   <= 1'b1;
                  end else begin
                     state     <= INST_BUSY;
                     ram_en    <= 1'b1;
                     ram_we    <= 4'b0000;
                     ram_addr  <= {inst_req_addr[31:2], 2'b00};
                     ram_wdata <= '0;
                  end
               end
            end

            INST_BUSY, DATA_BUSY: begin
               wait_cnt <= wait_cnt + 8'd1;
               // An ack in the final allowed cycle still counts as success.
               if (ram_ack || wait_cnt == 8'(MAX_WAIT - 1)) begin
                  state     <= RESP;
                  ram_en    <= 1'b0;
                  ram_we    <= '0;
                  ram_addr  <= '0;
                  ram_wdata <= '0;
                  if (state == INST_BUSY) begin
                     inst_resp_valid <= 1'b1;
                     inst_resp_err   <= !ram_ack;
                     inst_resp_rdata <= ram_ack ? ram_rdata : 32'h0;
                  end else begin
                     data_resp_valid <= 1'b1;
                     data_resp_err   <= !ram_ack;
                     data_resp_rdata <= (ram_ack && !req_write) ? ram_rdata : 32'h0;
                  end
               end
            end

            RESP: begin
               wait_cnt <= '0;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Randomized bench for data_ram_arbiter: a transaction-level model predicts grants,
// RAM strobes/lanes, response timing, errors and read data.
module tb_data_ram_arbiter;
   localparam int MAX_WAIT     = 15;
   localparam int STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req_valid;
   logic [31:0] inst_req_addr;
   logic        inst_req_ready;
   logic        inst_resp_valid;
   logic [31:0] inst_resp_rdata;
   logic        inst_resp_err;
   logic        data_req_valid;
   logic        data_req_write;
   logic [3:0]  data_req_sel;
   logic [31:0] data_req_addr;
   logic [31:0] data_req_wdata;
   logic        data_req_ready;
   logic        data_resp_valid;
   logic [31:0] data_resp_rdata;
   logic        data_resp_err;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        ram_ack;

   int total = 0;
   int bad   = 0;
   int starve_m = 0;
   int txn_no = 0;

   data_ram_arbiter #(.MAX_WAIT(MAX_WAIT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .rst(rst),
      .inst_req_valid(inst_req_valid), .inst_req_addr(inst_req_addr),
      .inst_req_ready(inst_req_ready), .inst_resp_valid(inst_resp_valid),
      .inst_resp_rdata(inst_resp_rdata), .inst_resp_err(inst_resp_err),
      .data_req_valid(data_req_valid), .data_req_write(data_req_write),
      .data_req_sel(data_req_sel), .data_req_addr(data_req_addr),
      .data_req_wdata(data_req_wdata), .data_req_ready(data_req_ready),
      .data_resp_valid(data_resp_valid), .data_resp_rdata(data_resp_rdata),
      .data_resp_err(data_resp_err),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .ram_ack(ram_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int size_of(input logic [3:0] sel);
      if (sel == 4'b0001) return 1;
      if (sel == 4'b0011) return 2;
      if (sel == 4'b1111) return 4;
      return 0;
   endfunction

   function automatic bit data_bad(input logic [3:0] sel, input logic [31:0] addr);
      int n = size_of(sel);
      if (n == 0) return 1'b1;
      return (addr % n) != 0;
   endfunction

   function automatic logic [3:0] exp_we(input logic [3:0] sel, input logic [31:0] addr);
      logic [3:0] we = '0;
      int n = size_of(sel);
      for (int k = 0; k < n; k++) we[(addr % 4) + k] = 1'b1;
      return we;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [3:0] sel, input logic [31:0] wd);
      logic [31:0] r = '0;
      int n = size_of(sel);
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % n)*8 +: 8];
      return r;
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic do_txn(input bit iv, input logic [31:0] ia, input bit dv, input bit dw,
                         input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dwd,
                         input int ack_dly, input logic [31:0] rd);
      bit inst_wins, is_err, wr, acked, exp_err;
      logic [31:0] addr, exp_rd;
      inst_req_valid = iv;  inst_req_addr = ia;
      data_req_valid = dv;  data_req_write = dw; data_req_sel = ds;
      data_req_addr  = da;  data_req_wdata = dwd;
      ram_ack   = 1'($urandom_range(1));
      ram_rdata = $urandom;
      inst_wins = iv && (!dv || starve_m == STARVE_LIMIT);
      #1;
      chk("inst_ready", {31'b0, inst_req_ready}, {31'b0, inst_wins});
      chk("data_ready", {31'b0, data_req_ready}, {31'b0, dv && !inst_wins});
      if (inst_wins || !iv) starve_m = 0;
      else starve_m++;
      is_err = inst_wins ? ((ia % 4) != 0) : data_bad(ds, da);
      wr     = !inst_wins && dw;
      addr   = inst_wins ? ia : da;
      acked  = 1'b0;
      @(posedge clk); @(negedge clk);
      inst_req_valid = 1'b1; data_req_valid = 1'b1; ram_ack = 1'b0;
      if (is_err) begin
         chk("misaligned_no_ram", {31'b0, ram_en}, 32'd0);
      end else begin
         for (int k = 0; k < MAX_WAIT && !acked; k++) begin
            chk("ram_en_busy", {31'b0, ram_en}, 32'd1);
            if (k == 0) begin
               chk("busy_ready", {30'b0, inst_req_ready, data_req_ready}, 32'd0);
               chk("ram_addr", ram_addr, {addr[31:2], 2'b00});
               chk("ram_we", {28'b0, ram_we}, {28'b0, wr ? exp_we(ds, da) : 4'b0000});
               if (wr) chk("ram_wdata", ram_wdata, exp_wdata(ds, dwd));
            end
            chk("busy_no_resp", {30'b0, inst_resp_valid, data_resp_valid}, 32'd0);
            if (k == ack_dly) begin
               ram_ack = 1'b1; ram_rdata = rd; acked = 1'b1;
            end
            @(posedge clk); @(negedge clk);
            ram_ack = 1'b0; ram_rdata = $urandom;
         end
      end
      exp_err = is_err || !acked;
      exp_rd  = (exp_err || wr) ? 32'h0 : rd;
      chk("ram_en_resp", {31'b0, ram_en}, 32'd0);
      chk("resp_valid", {30'b0, inst_resp_valid, data_resp_valid}, inst_wins ? 32'd2 : 32'd1);
      chk("resp_ready", {30'b0, inst_req_ready, data_req_ready}, 32'd0);
      if (inst_wins) begin
         chk("inst_rdata", inst_resp_rdata, exp_rd);
         chk("inst_err", {31'b0, inst_resp_err}, {31'b0, exp_err});
         chk("data_quiet", data_resp_rdata | {31'b0, data_resp_err}, 32'd0);
      end else begin
         chk("data_rdata", data_resp_rdata, exp_rd);
         chk("data_err", {31'b0, data_resp_err}, {31'b0, exp_err});
         chk("inst_quiet", inst_resp_rdata | {31'b0, inst_resp_err}, 32'd0);
      end
      ram_ack   = 1'($urandom_range(1));
      ram_rdata = $urandom;
      @(posedge clk); @(negedge clk);
      chk("post_resp", {29'b0, ram_en, inst_resp_valid, data_resp_valid}, 32'd0);
      $display("txn %0d: %s addr=%h wr=%0d err=%0d rdata=%h", txn_no,
               inst_wins ? "INST" : "DATA", addr, wr, exp_err, exp_rd);
      txn_no++;
      inst_req_valid = 1'b0; data_req_valid = 1'b0; ram_ack = 1'b0;
   endtask

   initial begin
      logic [31:0] a, b;
      logic [3:0]  s;
      bit iv, dv;
      int dly;
      rst = 1'b1;
      inst_req_valid = 0; inst_req_addr = 0;
      data_req_valid = 0; data_req_write = 0; data_req_sel = 0;
      data_req_addr = 0; data_req_wdata = 0; ram_rdata = 0; ram_ack = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ram", {ram_en, ram_we, 27'b0} | ram_addr | ram_wdata, 32'd0);
      chk("reset_resp", {inst_resp_valid, inst_resp_err, data_resp_valid, data_resp_err, 28'b0}
                        | inst_resp_rdata | data_resp_rdata, 32'd0);
      rst = 1'b0;

      do_txn(1, 32'h100, 0, 0, 4'b0000, 0, 0, 0, 32'hDEADBEEF);
      do_txn(0, 0, 1, 1, 4'b0001, 32'h203, 32'h000000A5, 1, 32'h12345678);
      do_txn(0, 0, 1, 0, 4'b0011, 32'h201, 0, 0, 32'h11111111);
      do_txn(0, 0, 1, 0, 4'b0101, 32'h200, 0, 0, 32'h22222222);
      do_txn(0, 0, 1, 1, 4'b0011, 32'h402, 32'h0000BEEF, 0, 32'h0);
      do_txn(0, 0, 1, 0, 4'b1111, 32'h300, 0, -1, 32'h33333333);
      do_txn(1, 32'h102, 0, 0, 4'b0000, 0, 0, 0, 32'h44444444);
      do_txn(0, 0, 1, 0, 4'b1111, 32'h304, 0, MAX_WAIT - 1, 32'h55555555);

      // Both requesters always valid: grants follow D,D,D,D,I,...
      for (int i = 0; i < 12; i++)
         do_txn(1, $urandom & 32'hFFFF_FFFC, 1, 1'($urandom_range(1)), 4'b1111,
                $urandom & 32'hFFFF_FFFC, $urandom, int'($urandom_range(2)), $urandom);

      // Reset while a store is in DATA_BUSY.
      data_req_valid = 1; data_req_write = 1; data_req_sel = 4'b1111;
      data_req_addr = 32'h500; data_req_wdata = 32'hCAFEF00D; ram_ack = 0;
      @(posedge clk); @(negedge clk);
      data_req_valid = 0;
      chk("rst_pre_busy", {31'b0, ram_en}, 32'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst_async_ram_en", {31'b0, ram_en}, 32'd0);
      chk("rst_no_resp", {30'b0, inst_resp_valid, data_resp_valid}, 32'd0);
      starve_m = 0;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_quiet", {29'b0, ram_en, inst_resp_valid, data_resp_valid}, 32'd0);
      end
      @(negedge clk);
      do_txn(0, 0, 1, 0, 4'b1111, 32'h500, 0, 0, 32'h600DF00D);

      for (int i = 0; i < 60; i++) begin
         iv = 1'($urandom_range(1));
         dv = 1'($urandom_range(1));
         if (!iv && !dv) dv = 1'b1;
         case ($urandom_range(3))
            0: s = 4'b0001;
            1: s = 4'b0011;
            2: s = 4'b1111;
            default: s = 4'($urandom);
         endcase
         a = $urandom;
         if ($urandom_range(1) == 0) a = a & 32'hFFFF_FFFC;
         b = $urandom;
         if ($urandom_range(3) != 0) b = b & 32'hFFFF_FFFC;
         dly = ($urandom_range(7) == 0) ? -1 : int'($urandom_range(5));
         do_txn(iv, b, dv, 1'($urandom_range(1)), s, a, $urandom, dly, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
